// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared RV32I control encodings; S_TRAP exists only with MULTICYCLE_FSM_ILLEGAL_TRAP_EN.
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READDATA = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: opcode to immediate-format select, shared with the pipelined core.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);
  always_comb begin
    imm_src = op == OP_STORE  ? IMM_S :
              op == OP_BRANCH ? IMM_B :
              op == OP_JAL    ? IMM_J : IMM_I;
  end
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: multicycle RV32I main control FSM.
// MULTICYCLE_FSM_ILLEGAL_TRAP_EN traps unknown opcodes in a sticky S_TRAP state.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_instr
);
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
  logic r_illegal;
  assign illegal_instr = r_illegal;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
  assign illegal_instr = 1'b0;
`endif
  state_t r_state;
  state_t w_dec_next;
  logic   w_pc_update;
  logic   w_branch;
  imm_src_decoder u_imm (.op(op), .imm_src(ImmSrc));
  always_comb begin
    w_dec_next = (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
                 op == OP_RTYPE  ? S_EXECUTER :
                 op == OP_ITYPE  ? S_EXECUTEI :
                 op == OP_JAL    ? S_JAL :
                 op == OP_BRANCH ? S_BEQ : ILLEGAL_NEXT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_STATE;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH:    r_state <= S_DECODE;
        S_DECODE:   r_state <= w_dec_next;
        S_MEMADR:   r_state <= op == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_JAL:      r_state <= S_ALUWB;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
        S_TRAP:     r_state <= S_TRAP;
`endif
        default:    r_state <= S_FETCH;
      endcase
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
      if (r_state == S_DECODE && w_dec_next == S_TRAP) r_illegal <= 1'b1;
`endif
    end
  end
  // Write enables are gated by rst so a reset mid-instruction issues no partial write.
  always_comb begin
    w_pc_update = r_state == S_FETCH || r_state == S_JAL;
    w_branch    = r_state == S_BEQ;
    PCWrite     = ~rst & (w_pc_update | (w_branch & zero));
    IRWrite     = ~rst & (r_state == S_FETCH);
    MemWrite    = ~rst & (r_state == S_MEMWRITE);
    RegWrite    = ~rst & (r_state == S_MEMWB || r_state == S_ALUWB);
    AdrSrc      = r_state == S_MEMREAD || r_state == S_MEMWRITE;
    instr_done  = r_state == S_MEMWB || r_state == S_MEMWRITE ||
                  r_state == S_ALUWB || r_state == S_BEQ;
    ResultSrc   = r_state == S_FETCH ? RES_ALURESULT :
                  r_state == S_MEMWB ? RES_READDATA : RES_ALUOUT;
    ALUSrcA     = (r_state == S_DECODE || r_state == S_JAL) ? SRCA_OLDPC :
                  (r_state == S_MEMADR || r_state == S_EXECUTER ||
                   r_state == S_EXECUTEI || r_state == S_BEQ) ? SRCA_RS1 : SRCA_PC;
    ALUSrcB     = (r_state == S_FETCH || r_state == S_JAL) ? SRCB_FOUR :
                  (r_state == S_DECODE || r_state == S_MEMADR ||
                   r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
    ALUOp       = (r_state == S_EXECUTER || r_state == S_EXECUTEI) ? ALUOP_FUNCT :
                  r_state == S_BEQ ? ALUOP_SUB : ALUOP_ADD;
  end
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed per-cycle checks of every control output.
module tb_multicycle_main_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  int n_assert = 0;
  int n_fail = 0;
  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,instr_done,illegal_instr}
  localparam logic [14:0] E_FETCH    = 15'b1001_10_00_10_00_000;
  localparam logic [14:0] E_RFETCH   = 15'b0000_10_00_10_00_000;
  localparam logic [14:0] E_DECODE   = 15'b0000_00_01_01_00_000;
  localparam logic [14:0] E_MEMADR   = 15'b0000_00_10_01_00_000;
  localparam logic [14:0] E_MEMREAD  = 15'b0100_00_00_00_00_000;
  localparam logic [14:0] E_MEMWB    = 15'b0000_01_00_00_00_110;
  localparam logic [14:0] E_MEMWRITE = 15'b0110_00_00_00_00_010;
  localparam logic [14:0] E_RMEMWR   = 15'b0100_00_00_00_00_010;
  localparam logic [14:0] E_EXECR    = 15'b0000_00_10_00_10_000;
  localparam logic [14:0] E_EXECI    = 15'b0000_00_10_01_10_000;
  localparam logic [14:0] E_ALUWB    = 15'b0000_00_00_00_00_110;
  localparam logic [14:0] E_JAL      = 15'b1000_00_01_10_00_000;
  localparam logic [14:0] E_BEQ1     = 15'b1000_00_10_00_01_010;
  localparam logic [14:0] E_BEQ0     = 15'b0000_00_10_00_01_010;
  localparam logic [14:0] E_TRAP     = 15'b0000_00_00_00_00_001;
  multicycle_main_fsm dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .instr_done(instr_done), .illegal_instr(illegal_instr)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [14:0] e, input logic [1:0] imm);
    logic [16:0] got;
    logic [16:0] exp;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
           RegWrite, instr_done, illegal_instr, ImmSrc};
    exp = {e, imm};
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1; op = 7'b0000011; zero = 1'b0;
    tick; tick;
    chk("reset_fetch", E_RFETCH, 2'b00);
    rst = 1'b0; #1;
    chk("lw_fetch", E_FETCH, 2'b00);
    tick; chk("lw_decode", E_DECODE, 2'b00);
    tick; chk("lw_memadr", E_MEMADR, 2'b00);
    tick; chk("lw_memread", E_MEMREAD, 2'b00);
    tick; chk("lw_memwb", E_MEMWB, 2'b00);
    tick; op = 7'b0110011; #1;
    chk("r_fetch", E_FETCH, 2'b00);
    tick; chk("r_decode", E_DECODE, 2'b00);
    tick; chk("r_execr", E_EXECR, 2'b00);
    tick; chk("r_aluwb", E_ALUWB, 2'b00);
    tick; op = 7'b1100011; #1;
    chk("beq1_fetch", E_FETCH, 2'b10);
    tick; chk("beq1_decode", E_DECODE, 2'b10);
    zero = 1'b1;
    tick; chk("beq1_taken", E_BEQ1, 2'b10);
    zero = 1'b0; #1;
    chk("beq1_zero_drop", E_BEQ0, 2'b10);
    tick; chk("beq0_fetch", E_FETCH, 2'b10);
    tick; chk("beq0_decode", E_DECODE, 2'b10);
    tick; chk("beq0_not_taken", E_BEQ0, 2'b10);
    tick; op = 7'b0100011; #1;
    chk("sw_fetch", E_FETCH, 2'b01);
    tick; chk("sw_decode", E_DECODE, 2'b01);
    tick; chk("sw_memadr", E_MEMADR, 2'b01);
    tick; chk("sw_memwrite", E_MEMWRITE, 2'b01);
    tick; op = 7'b0010011; #1;
    chk("i_fetch", E_FETCH, 2'b00);
    tick; chk("i_decode", E_DECODE, 2'b00);
    tick; chk("i_execi", E_EXECI, 2'b00);
    tick; chk("i_aluwb", E_ALUWB, 2'b00);
    tick; op = 7'b1101111; #1;
    chk("jal_fetch", E_FETCH, 2'b11);
    tick; chk("jal_decode", E_DECODE, 2'b11);
    tick; chk("jal_jal", E_JAL, 2'b11);
    tick; chk("jal_aluwb", E_ALUWB, 2'b11);
    tick; op = 7'b0100011; #1;
    chk("swr_fetch", E_FETCH, 2'b01);
    tick; chk("swr_decode", E_DECODE, 2'b01);
    tick; chk("swr_memadr", E_MEMADR, 2'b01);
    tick; rst = 1'b1; #1;
    chk("swr_memwrite_rst", E_RMEMWR, 2'b01);
    tick; chk("swr_after_rst", E_RFETCH, 2'b01);
    rst = 1'b0; #1;
    chk("swr_fetch_release", E_FETCH, 2'b01);
    op = 7'b1111111; #1;
    chk("ill_fetch", E_FETCH, 2'b00);
    tick; chk("ill_decode", E_DECODE, 2'b00);
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
    tick; chk("ill_trap", E_TRAP, 2'b00);
    tick; chk("ill_trap_hold", E_TRAP, 2'b00);
    op = 7'b0000011; #1;
    tick; chk("ill_trap_hold2", E_TRAP, 2'b00);
    rst = 1'b1;
    tick; chk("ill_rst_clear", E_RFETCH, 2'b00);
    rst = 1'b0; #1;
`else
    tick; chk("ill_nop_fetch", E_FETCH, 2'b00);
    tick; chk("ill_nop_decode", E_DECODE, 2'b00);
    op = 7'b0000011; #1;
    tick; chk("ill_then_memadr", E_MEMADR, 2'b00);
    rst = 1'b1;
    tick; chk("ill_rst", E_RFETCH, 2'b00);
    rst = 1'b0; #1;
`endif
    chk("final_fetch", E_FETCH, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sits directly upstream of the ALU decoder: produces the 2-bit ALUOp it consumes, plus every datapath mux select and write enable.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states, driven by the opcode held in the instruction register and the ALU zero flag.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (kept parameterised for bring-up only; production value fixed).

Ports:
- clk  in  1  core clock, all state changes on rising edge
- rst  in  1  synchronous active-high reset
- op  in  7  instruction opcode field from instruction register
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable = PCUpdate OR (Branch AND zero)
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/oldPC register enable
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- ALUSrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode by funct
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- instr_done  out  1  high in the final state of every instruction
- illegal_instr  out  1  sticky illegal-opcode flag

Behaviour:
- Moore FSM: all outputs are a function of state only, except PCWrite (combinational with zero) and ImmSrc (combinational on op). Unlisted outputs are 0 in every state.
- Reset:
  - rst high at a clock edge sets state to S_FETCH and clears illegal_instr.
  - While rst is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 regardless of state.
  - Reset mid-instruction abandons it; no partial write is issued in the reset cycle.
- State outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other value → see Optional Feature
  - MEMADR: op=0000011 → MEMREAD, otherwise → MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH.
  - JAL→ALUWB.
  - BEQ→FETCH.
- Latency in cycles: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3.
- ImmSrc:
  - 0000011 and 0010011 → 00; 0100011 → 01; 1100011 → 10; 1101111 → 11.
  - Any other opcode → 00.
- Unreachable state encodings go to S_FETCH on the next edge.

Optional Feature:
- Macro MULTICYCLE_FSM_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised op in DECODE → S_TRAP, which sets illegal_instr=1.
  - S_TRAP holds with all enables 0 until rst.
- Undefined:
  - An unrecognised op in DECODE → FETCH (treated as a 2-cycle NOP, instr_done not asserted).
  - illegal_instr is tied to 0 and S_TRAP does not exist.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH)
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings
- One combinational sub-module, imm_src_decoder (op → ImmSrc), reused by the pipelined core.

Test Plan:
- rst high 2 cycles, then op=0000011 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5, ResultSrc=01 there, instr_done pulses once.
- op=0110011 → EXECUTER shows ALUOp=10, ALUSrcA=10, ALUSrcB=00; ALUWB RegWrite=1; 4 cycles total.
- op=1100011 with zero=1 in BEQ → PCWrite=1 in BEQ; repeat with zero=0 → PCWrite=0; ALUOp=01 both times.
- op=0100011 → MemWrite=1 for exactly one cycle (MEMWRITE) with AdrSrc=1, RegWrite never asserted.
- rst asserted during MEMWRITE → MemWrite=0 that cycle; state=FETCH after the edge; IRWrite=1 the cycle after rst drops.
- op=1111111 → with macro, illegal_instr=1 and all enables 0 until rst; without macro, FETCH follows DECODE and illegal_instr stays 0.
